// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares one combinational 4-bit ALU between two requesters.
// It latches the winning operation, holds it on the ALU, samples the outcome and returns it.
module alu_req_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [3:0]  IDLE_OPCODE   = 4'hF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req_valid,
  output logic [1:0] o_req_ready,
  input  logic [3:0] i_req0_opcode,
  input  logic [3:0] i_req0_a,
  input  logic [3:0] i_req0_b,
  input  logic [3:0] i_req1_opcode,
  input  logic [3:0] i_req1_a,
  input  logic [3:0] i_req1_b,
  output logic [3:0] o_alu_opcode,
  output logic [3:0] o_alu_a,
  output logic [3:0] o_alu_b,
  input  logic [7:0] i_alu_result,
  input  logic       i_alu_gt,
  input  logic       i_alu_st,
  input  logic       i_alu_eq,
  input  logic       i_alu_ovf,
  input  logic       i_alu_done,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic       o_rsp_id,
  output logic [7:0] o_rsp_result,
  output logic       o_rsp_gt,
  output logic       o_rsp_st,
  output logic       o_rsp_eq,
  output logic       o_rsp_ovf,
  output logic       o_rsp_err,
  output logic       o_busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [3:0] CntLast = 4'(SETTLE_CYCLES - 1);

  state_e     r_state;
  logic       r_rr_ptr;
  logic [3:0] r_cnt;
  logic       r_id;
  logic [3:0] r_alu_opcode;
  logic [3:0] r_alu_a;
  logic [3:0] r_alu_b;
  logic       r_rsp_valid;
  logic       r_rsp_id;
  logic [7:0] r_rsp_result;
  logic       r_rsp_gt;
  logic       r_rsp_st;
  logic       r_rsp_eq;
  logic       r_rsp_ovf;
  logic       r_rsp_err;

  logic       w_grant;
  logic       w_grant_id;
  logic [3:0] w_sel_opcode;
  logic [3:0] w_sel_a;
  logic [3:0] w_sel_b;
  logic       w_is_cmp;
  logic       w_is_arith;

  always_comb begin
    // Contention goes to the round-robin pointer; otherwise the lone requester wins.
    w_grant_id   = (i_req_valid == 2'b11) ? r_rr_ptr : i_req_valid[1];
    w_grant      = (r_state == StIdle) && (|i_req_valid);
    o_req_ready  = 2'b00;
    if (w_grant) o_req_ready = w_grant_id ? 2'b10 : 2'b01;
    w_sel_opcode = w_grant_id ? i_req1_opcode : i_req0_opcode;
    w_sel_a      = w_grant_id ? i_req1_a : i_req0_a;
    w_sel_b      = w_grant_id ? i_req1_b : i_req0_b;
    w_is_cmp     = (r_alu_opcode >= 4'd3) && (r_alu_opcode <= 4'd5);
    w_is_arith   = (r_alu_opcode >= 4'd6) && (r_alu_opcode <= 4'd9);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_rr_ptr     <= 1'b0;
      r_cnt        <= 4'd0;
      r_id         <= 1'b0;
      r_alu_opcode <= IDLE_OPCODE;
      r_alu_a      <= 4'd0;
      r_alu_b      <= 4'd0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= 8'd0;
      r_rsp_gt     <= 1'b0;
      r_rsp_st     <= 1'b0;
      r_rsp_eq     <= 1'b0;
      r_rsp_ovf    <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_grant) begin
            r_alu_opcode <= w_sel_opcode;
            r_alu_a      <= w_sel_a;
            r_alu_b      <= w_sel_b;
            r_id         <= w_grant_id;
            r_rr_ptr     <= ~w_grant_id;
            r_cnt        <= 4'd0;
            r_state      <= StExec;
          end
        end
        StExec: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == CntLast) begin
            // Flags and overflow are only meaningful for their own opcode classes.
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= r_id;
            r_rsp_result <= i_alu_done ? i_alu_result : 8'd0;
            r_rsp_err    <= ~i_alu_done;
            r_rsp_ovf    <= w_is_arith & i_alu_ovf;
            r_rsp_gt     <= w_is_cmp & i_alu_gt;
            r_rsp_st     <= w_is_cmp & i_alu_st;
            r_rsp_eq     <= w_is_cmp & i_alu_eq;
            r_state      <= StResp;
          end
        end
        StResp: begin
          if (i_rsp_ready) begin
            r_rsp_valid  <= 1'b0;
            r_alu_opcode <= IDLE_OPCODE;
            r_alu_a      <= 4'd0;
            r_alu_b      <= 4'd0;
            r_state      <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_alu_opcode = r_alu_opcode;
  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_gt     = r_rsp_gt;
  assign o_rsp_st     = r_rsp_st;
  assign o_rsp_eq     = r_rsp_eq;
  assign o_rsp_ovf    = r_rsp_ovf;
  assign o_rsp_err    = r_rsp_err;
  assign o_busy       = (r_state != StIdle);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: an ALU model with stale flags, directed vectors, corner sequences
// and a randomized run checked cycle-by-cycle against a transaction-level reference.
module tb_alu_req_arbiter;

  localparam int unsigned Settle = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req0_opcode, req0_a, req0_b, req1_opcode, req1_a, req1_b;
  logic [3:0] alu_opcode, alu_a, alu_b;
  logic [7:0] alu_result;
  logic       alu_gt, alu_st, alu_eq, alu_ovf, alu_done;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_result;
  logic       rsp_gt, rsp_st, rsp_eq, rsp_ovf, rsp_err, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_req_arbiter #(.SETTLE_CYCLES(Settle), .IDLE_OPCODE(4'hF)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req0_opcode(req0_opcode), .i_req0_a(req0_a), .i_req0_b(req0_b),
    .i_req1_opcode(req1_opcode), .i_req1_a(req1_a), .i_req1_b(req1_b),
    .o_alu_opcode(alu_opcode), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .i_alu_result(alu_result), .i_alu_gt(alu_gt), .i_alu_st(alu_st), .i_alu_eq(alu_eq),
    .i_alu_ovf(alu_ovf), .i_alu_done(alu_done),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
    .o_rsp_result(rsp_result), .o_rsp_gt(rsp_gt), .o_rsp_st(rsp_st), .o_rsp_eq(rsp_eq),
    .o_rsp_ovf(rsp_ovf), .o_rsp_err(rsp_err), .o_busy(busy)
  );

  // Reference ALU arithmetic: returns {ovf, gt, st, eq, result}.
  function automatic logic [11:0] ref_alu(input logic [3:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
    logic [7:0] r;
    logic       ovf;
    r   = 8'd0;
    ovf = 1'b0;
    case (op)
      4'd0: r = {4'd0, ~(a & b)};
      4'd1: r = {4'd0, ~(a | b)};
      4'd2: r = {4'd0, ~(a ^ b)};
      4'd6: begin r = {4'd0, a} + {4'd0, b}; ovf = (r > 8'd15); end
      4'd7: begin r = {4'd0, a} - {4'd0, b}; ovf = (a < b); end
      4'd8: begin r = {4'd0, a} * {4'd0, b}; ovf = (r > 8'd15); end
      4'd9: begin
        if (b == 4'd0) begin r = 8'hFF; ovf = 1'b1; end
        else r = {4'd0, a / b};
      end
      default: r = 8'd0;
    endcase
    return {ovf, (a > b), (a < b), (a == b), r};
  endfunction

  // Expected response {id, err, ovf, gt, st, eq, result} by the masking rules.
  function automatic logic [13:0] exp_rsp(input logic id, input logic [3:0] op,
                                          input logic [3:0] a, input logic [3:0] b);
    logic [11:0] f;
    logic        cmp, arith;
    f     = ref_alu(op, a, b);
    cmp   = (op >= 4'd3) && (op <= 4'd5);
    arith = (op >= 4'd6) && (op <= 4'd9);
    if (op > 4'd9) return {id, 1'b1, 1'b0, 3'b000, 8'd0};
    return {id, 1'b0, f[11] & arith, f[10] & cmp, f[9] & cmp, f[8] & cmp, f[7:0]};
  endfunction

  // Bench ALU: flags level-held outside compare ops, junk ovf/result where undefined.
  logic [2:0] held_flags = 3'b111;
  always @(posedge clk)
    if (alu_opcode >= 4'd3 && alu_opcode <= 4'd5) held_flags <= {alu_gt, alu_st, alu_eq};

  always_comb begin
    logic [11:0] f;
    f          = ref_alu(alu_opcode, alu_a, alu_b);
    alu_done   = (alu_opcode <= 4'd9);
    alu_result = alu_done ? f[7:0] : 8'hA5;
    alu_ovf    = (alu_opcode >= 4'd6 && alu_opcode <= 4'd9) ? f[11] : 1'b1;
    {alu_gt, alu_st, alu_eq} = (alu_opcode >= 4'd3 && alu_opcode <= 4'd5) ? f[10:8]
                                                                         : held_flags;
  end

  function automatic logic [13:0] act_rsp();
    return {rsp_id, rsp_err, rsp_ovf, rsp_gt, rsp_st, rsp_eq, rsp_result};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic set_req(input logic id, input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b);
    if (id) begin req1_opcode = op; req1_a = a; req1_b = b; end
    else begin req0_opcode = op; req0_a = a; req0_b = b; end
  endtask

  // Waits (bounded) until rsp_valid is seen; returns edges waited.
  task automatic wait_rsp(input string name, output int edges);
    edges = 0;
    while (!rsp_valid && edges < 40) begin
      step();
      edges++;
    end
    if (!rsp_valid) chk({name, "_timeout"}, 0, 1);
  endtask

  // Issues one op from a single requester, checks the response and its latency.
  task automatic do_op(input string name, input logic id, input logic [3:0] op,
                       input logic [3:0] a, input logic [3:0] b, input logic [13:0] exp);
    int n;
    set_req(id, op, a, b);
    req_valid = id ? 2'b10 : 2'b01;
    #1;
    n = 0;
    while (req_ready != req_valid && n < 40) begin
      step();
      n++;
    end
    chk({name, "_ready"}, req_ready, req_valid);
    step();
    req_valid = 2'b00;
    set_req(id, 4'd0, 4'd0, 4'd0);
    wait_rsp(name, n);
    // Accepting edge plus the edges until rsp_valid is visible.
    chk({name, "_latency"}, n + 1, Settle + 1);
    chk({name, "_rsp"}, act_rsp(), exp);
    step();
    chk({name, "_rsp_drop"}, rsp_valid, 0);
  endtask

  typedef struct {
    logic        id;
    logic [3:0]  op;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [13:0] snap;
  int          n;
  int          m_rr, win, m_exec;
  bit          m_busy, m_resp;
  logic [13:0] m_exp;
  logic [1:0]  exp_ready;
  logic [1:0]  rv;

  initial begin
    req0_opcode = 4'd0; req0_a = 4'd0; req0_b = 4'd0;
    req1_opcode = 4'd0; req1_a = 4'd0; req1_b = 4'd0;
    do_reset();

    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp", act_rsp(), 0);
    chk("reset_alu_op", alu_opcode, 4'hF);
    chk("reset_alu_ab", {alu_a, alu_b}, 0);
    chk("reset_ready", req_ready, 0);

    // {id, err, ovf, gt, st, eq, result}
    vecs.push_back('{0, 4'd6, 4'd7, 4'd9, {1'b0, 1'b0, 1'b1, 3'b000, 8'd16}});
    vecs.push_back('{1, 4'd3, 4'd5, 4'd2, {1'b1, 1'b0, 1'b0, 3'b100, 8'd0}});
    vecs.push_back('{1, 4'd6, 4'd1, 4'd1, {1'b1, 1'b0, 1'b0, 3'b000, 8'd2}});
    vecs.push_back('{0, 4'hC, 4'd3, 4'd4, {1'b0, 1'b1, 1'b0, 3'b000, 8'd0}});
    vecs.push_back('{0, 4'd0, 4'hC, 4'hA, {1'b0, 1'b0, 1'b0, 3'b000, 8'h07}});
    vecs.push_back('{1, 4'd2, 4'd5, 4'd3, {1'b1, 1'b0, 1'b0, 3'b000, 8'h09}});
    vecs.push_back('{0, 4'd4, 4'd2, 4'd5, {1'b0, 1'b0, 1'b0, 3'b010, 8'd0}});
    vecs.push_back('{0, 4'd5, 4'd3, 4'd3, {1'b0, 1'b0, 1'b0, 3'b001, 8'd0}});
    vecs.push_back('{1, 4'd9, 4'd9, 4'd2, {1'b1, 1'b0, 1'b0, 3'b000, 8'd4}});
    vecs.push_back('{0, 4'd9, 4'd5, 4'd0, {1'b0, 1'b0, 1'b1, 3'b000, 8'hFF}});
    vecs.push_back('{1, 4'd7, 4'd2, 4'd5, {1'b1, 1'b0, 1'b1, 3'b000, 8'hFD}});
    vecs.push_back('{0, 4'd1, 4'd5, 4'd2, {1'b0, 1'b0, 1'b0, 3'b000, 8'h08}});
    foreach (vecs[i]) do_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].op, vecs[i].a,
                            vecs[i].b, vecs[i].exp);

    // Both valid from reset: req0 first, then req1, pointer returns to 0.
    do_reset();
    set_req(0, 4'd8, 4'd15, 4'd15);
    set_req(1, 4'd7, 4'd9, 4'd4);
    req_valid = 2'b11;
    #1;
    chk("rr_first", req_ready, 2'b01);
    step();
    req_valid = 2'b10;
    chk("rr_busy_ready", req_ready, 2'b00);
    wait_rsp("rr_a", n);
    chk("rr_rsp0", act_rsp(), {1'b0, 1'b0, 1'b1, 3'b000, 8'd225});
    step();
    chk("rr_second", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    wait_rsp("rr_b", n);
    chk("rr_rsp1", act_rsp(), {1'b1, 1'b0, 1'b0, 3'b000, 8'd5});
    step();
    req_valid = 2'b11;
    #1;
    chk("rr_wrap", req_ready, 2'b01);
    req_valid = 2'b00;
    #1;

    // Backpressure: response held, nothing accepted, req1 granted after the handshake.
    rsp_ready = 1'b0;
    set_req(0, 4'd6, 4'd2, 4'd3);
    req_valid = 2'b01;
    step();
    set_req(1, 4'd8, 4'd3, 4'd3);
    req_valid = 2'b10;
    wait_rsp("bp", n);
    snap = act_rsp();
    chk("bp_rsp", snap, {1'b0, 1'b0, 1'b0, 3'b000, 8'd5});
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {rsp_valid, act_rsp()}, {1'b1, snap});
      chk("bp_ready", req_ready, 2'b00);
      chk("bp_busy", busy, 1);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_idle_grant", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    chk("bp_busy_again", busy, 1);
    wait_rsp("bp2", n);
    chk("bp_rsp1", act_rsp(), {1'b1, 1'b0, 1'b0, 3'b000, 8'd9});
    step();

    // Reset during EXEC discards the operation.
    set_req(0, 4'd6, 4'd4, 4'd4);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    chk("rst_was_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {busy, rsp_valid, alu_opcode, alu_a, alu_b}, {2'b00, 4'hF, 8'h00});
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_no_rsp", rsp_valid, 0);
      step();
    end
    do_op("post_rst", 1'b0, 4'd6, 4'd3, 4'd4, {1'b0, 1'b0, 1'b0, 3'b000, 8'd7});

    // Randomized run against a transaction-level model.
    do_reset();
    m_rr = 0; m_busy = 0; m_exec = 0; m_resp = 0; m_exp = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rv = 2'($urandom_range(0, 3));
      req_valid = rv;
      set_req(0, 4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom));
      set_req(1, 4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = 2'b00;
      win = 0;
      if (!m_busy && rv != 2'b00) begin
        win = (rv == 2'b11) ? m_rr : (rv == 2'b10 ? 1 : 0);
        exp_ready = (win == 1) ? 2'b10 : 2'b01;
      end
      chk("rnd_ready", req_ready, exp_ready);
      chk("rnd_busy", busy, m_busy);
      chk("rnd_valid", rsp_valid, m_resp);
      if (m_resp) chk("rnd_rsp", act_rsp(), m_exp);
      if (exp_ready != 2'b00) begin
        m_exp  = (win == 1) ? exp_rsp(1'b1, req1_opcode, req1_a, req1_b)
                            : exp_rsp(1'b0, req0_opcode, req0_a, req0_b);
        m_rr   = 1 - win;
        m_busy = 1;
        m_exec = Settle;
      end else if (m_exec > 0) begin
        m_exec--;
        if (m_exec == 0) m_resp = 1;
      end else if (m_resp && rsp_ready) begin
        m_resp = 0;
        m_busy = 0;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
